hamming_11_7_dec: RTL and testbench
===================================

Name: hamming_11_7_dec

Overview:
Registered Hamming (11,7) single-error-correcting decoder. It sits directly downstream of the hamming_11_7 encoder / channel and consumes its 11-bit codeword. Each codeword is checked, any single-bit error is corrected, and the 7-bit data is delivered through a 2-stage valid/ready pipeline. Saturating error counters are kept for link-health monitoring.

Parameters:
CNT_W, 16, width of the corrected and uncorrectable error counters (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  code_in valid
in_ready  output  1  decoder accepts code_in this cycle
code_in  input  11  codeword {d6,d5,d4,p4,d3,d2,d1,p3,d0,p2,p1}; bit i = Hamming position i+1
out_valid  output  1  data_out and flags valid
out_ready  input  1  downstream accepts output
data_out  output  7  corrected data {d6..d0}
err_corr  output  1  single error found and corrected for this word
err_uncorr  output  1  invalid syndrome (12..15); data not corrected
syndrome_out  output  4  raw syndrome {s4,s3,s2,s1} for this word
cnt_clear  input  1  synchronous clear of both counters
corr_count  output  CNT_W  saturating count of corrected words
uncorr_count  output  CNT_W  saturating count of uncorrectable words

Behaviour:
- Reset (async, rst=1): both stage valids=0, out_valid=0, data_out=0, err_corr=0, err_uncorr=0, syndrome_out=0, both counters=0. in_ready=1 once rst deasserts.
- Syndrome, computed combinationally on code_in and registered in stage 1 with the codeword:
  - s1 = c0^c2^c4^c6^c8^c10
  - s2 = c1^c2^c5^c6^c9^c10
  - s3 = c3^c4^c5^c6
  - s4 = c7^c8^c9^c10
- Stage 2 decode:
  - S=0: no error; err_corr=0, err_uncorr=0.
  - S=1..11: invert code bit S-1; err_corr=1, err_uncorr=0. A parity-bit error (S=1,2,4,8) still sets err_corr, but the data is unchanged.
  - S=12..15: err_uncorr=1, err_corr=0; data_out = raw data bits {c10,c9,c8,c6,c5,c4,c2}.
  - Double errors that alias to S<=11 are miscorrected. This is a known SEC-only limitation, not detected.
- Extraction: data_out = {c10,c9,c8,c6,c5,c4,c2} taken after correction.
- Handshake:
  - Stage 2 is the output register. s2_adv = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_adv. Input transfer = in_valid & in_ready.
  - Stage 1 loads on input transfer. Stage 1 moves into stage 2 when s2_adv. Stage 1 clears when its word moves with no new input.
  - Latency 2 cycles from input transfer to out_valid with out_ready held high. Full throughput of 1 word/cycle.
  - Under stall (out_valid & !out_ready): data_out, flags and syndrome_out hold stable. in_ready falls once stage 1 is also full, with no loss and no duplication.
- Counters:
  - On output transfer (out_valid & out_ready): corr_count += err_corr; uncorr_count += err_uncorr.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - cnt_clear has priority: a same-cycle increment is dropped and the counter reads 0 next cycle.
- Reset mid-operation: in-flight words are discarded and counters are zeroed. No output transfer occurs in the reset cycle.

Test Plan:
1. Clean word: code_in=0x52F, out_ready=1 -> 2 cycles later data_out=0x55, syndrome_out=0, err_corr=0, err_uncorr=0, counters unchanged.
2. Data-bit error: code_in=0x53F (bit 4 flipped) -> data_out=0x55, syndrome_out=5, err_corr=1, corr_count=1.
3. Parity-bit error: code_in=0x52E (bit 0 flipped) -> data_out=0x55, syndrome_out=1, err_corr=1. Uncorrectable: code_in=0x5A7 (bits 3 and 7 flipped) -> syndrome_out=12, err_uncorr=1, data_out=0x55, uncorr_count=1.
4. Backpressure:
   - Stream 5 words back-to-back with out_ready=0 for 4 cycles. in_ready must drop after 2 words are accepted, and out_valid/data_out must hold stable.
   - Release out_ready. All 5 words appear in order, with no drops or duplicates.
5. Exhaustive: all 128 data values × 12 error patterns (none plus each single bit, 0..10) -> data_out always equals the original data, and err_corr=1 exactly when an error was injected.
6. Counter edges:
   - CNT_W=2: five corrected words -> corr_count saturates at 3.
   - Assert cnt_clear in the same cycle as a corrected output transfer -> corr_count=0.
   - Assert rst mid-stream -> out_valid=0 and counters=0 immediately (async).

Source files
------------

// File: rtl/hamming_11_7_dec.sv
// Hamming (11,7) single-error-correcting decoder with a 2-stage valid/ready
// pipeline and saturating corrected/uncorrectable word counters.
// Codeword layout: bit i carries Hamming position i+1,
// {d6,d5,d4,p4,d3,d2,d1,p3,d0,p2,p1}.
module hamming_11_7_dec #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       data_out,
    output logic             err_corr,
    output logic             err_uncorr,
    output logic [3:0]       syndrome_out,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    // Stage 1 state. Only the seven data positions are kept alongside the
    // syndrome: the parity positions are never needed after the syndrome is
    // formed, so correcting them reduces to reporting err_corr.
    logic       s1_valid;
    logic [6:0] s1_data;
    logic [3:0] s1_syn;

    logic [3:0] syn_in;
    logic [6:0] raw_data_in;
    logic       s2_adv;
    logic       in_fire;
    logic       out_fire;

    logic [6:0] fix_data;
    logic       fix_corr;
    logic       fix_uncorr;

    // Syndrome and raw data bits taken straight from the incoming codeword
    always_comb begin
        syn_in[0]   = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6] ^ code_in[8] ^ code_in[10];
        syn_in[1]   = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6] ^ code_in[9] ^ code_in[10];
        syn_in[2]   = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];
        syn_in[3]   = code_in[7] ^ code_in[8] ^ code_in[9] ^ code_in[10];
        raw_data_in = {code_in[10], code_in[9], code_in[8], code_in[6],
                       code_in[5], code_in[4], code_in[2]};
    end

    // Pipeline handshake: stage 2 is the output register
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        in_ready = !s1_valid || s2_adv;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    // Stage 1: capture codeword data and syndrome, drain when its word moves on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= raw_data_in;
            s1_syn   <= syn_in;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Decode: flip the data bit addressed by the syndrome; parity-position
    // syndromes (1,2,4,8) flag a correction with data untouched
    always_comb begin
        fix_data   = s1_data;
        fix_corr   = 1'b0;
        fix_uncorr = 1'b0;
        if (s1_syn >= 4'd12) begin
            fix_uncorr = 1'b1;
        end else if (s1_syn != 4'd0) begin
            fix_corr = 1'b1;
            case (s1_syn)
                4'd3:    fix_data[0] = ~s1_data[0];
                4'd5:    fix_data[1] = ~s1_data[1];
                4'd6:    fix_data[2] = ~s1_data[2];
                4'd7:    fix_data[3] = ~s1_data[3];
                4'd9:    fix_data[4] = ~s1_data[4];
                4'd10:   fix_data[5] = ~s1_data[5];
                4'd11:   fix_data[6] = ~s1_data[6];
                default: fix_data    = s1_data;
            endcase
        end
    end

    // Stage 2: output register, holds steady while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            data_out     <= '0;
            err_corr     <= 1'b0;
            err_uncorr   <= 1'b0;
            syndrome_out <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out     <= fix_data;
                err_corr     <= fix_corr;
                err_uncorr   <= fix_uncorr;
                syndrome_out <= s1_syn;
            end
        end
    end

    // Saturating error counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (cnt_clear) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (out_fire) begin
            if (err_corr && (corr_count != '1)) begin
                corr_count <= corr_count + 1'b1;
            end
            if (err_uncorr && (uncorr_count != '1)) begin
                uncorr_count <= uncorr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_11_7_dec.sv
// Scoreboard bench for hamming_11_7_dec (counter width 2 for saturation).
module tb_hamming_11_7_dec;

    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [10:0]   code_in;
    logic          out_valid;
    logic          out_ready;
    logic [6:0]    data_out;
    logic          err_corr;
    logic          err_uncorr;
    logic [3:0]    syndrome_out;
    logic          cnt_clear;
    logic [CW-1:0] corr_count;
    logic [CW-1:0] uncorr_count;

    typedef struct packed {
        logic [6:0] data;
        logic       corr;
        logic       uncorr;
        logic [3:0] syn;
    } exp_t;

    exp_t q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    hamming_11_7_dec #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .code_in      (code_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .err_corr     (err_corr),
        .err_uncorr   (err_uncorr),
        .syndrome_out (syndrome_out),
        .cnt_clear    (cnt_clear),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] encode(input logic [6:0] d);
        logic [10:0] c;
        c     = '0;
        c[2]  = d[0];
        c[4]  = d[1];
        c[5]  = d[2];
        c[6]  = d[3];
        c[8]  = d[4];
        c[9]  = d[5];
        c[10] = d[6];
        c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
        c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
        c[3]  = c[4] ^ c[5] ^ c[6];
        c[7]  = c[8] ^ c[9] ^ c[10];
        return c;
    endfunction

    function automatic exp_t mk(input logic [6:0] d, input logic c, input logic u, input logic [3:0] s);
        exp_t e;
        e.data = d; e.corr = c; e.uncorr = u; e.syn = s;
        return e;
    endfunction

    // Present one word; push its expectation when the DUT accepts it
    task automatic send(input logic [10:0] code, input exp_t e, output int unsigned cyc);
        logic acc;
        acc = 1'b0;
        cyc = 0;
        in_valid = 1'b1;
        code_in  = code;
        while (!acc && cyc < 100) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                q.push_back(e);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    // Monitor: compare on every output transfer, and check stall hold
    logic stall_prev = 1'b0;
    exp_t prev_word;
    always @(negedge clk) begin
        exp_t cur;
        exp_t want;
        cur = mk(data_out, err_corr, err_uncorr, syndrome_out);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", cur, prev_word);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    want = q.pop_front();
                    chk("data_out", cur.data, want.data);
                    chk("err_corr", cur.corr, want.corr);
                    chk("err_uncorr", cur.uncorr, want.uncorr);
                    chk("syndrome", cur.syn, want.syn);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_word  = cur;
        end
    end

    initial begin
        int unsigned cyc;
        int unsigned sum;
        logic [3:0]  exp_ir;
        rst = 1'b1; in_valid = 1'b0; code_in = '0; out_ready = 1'b1; cnt_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_flags", {err_corr, err_uncorr}, 0);
        chk("rst_syn", syndrome_out, 0);
        chk("rst_counts", {corr_count, uncorr_count}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        // clean word with latency check
        send(11'h52F, mk(7'h55, 0, 0, 4'd0), cyc);
        @(negedge clk);
        chk("lat_first", out_valid, 0);
        @(negedge clk);
        chk("lat_second", out_valid, 1);
        @(posedge clk); #1;
        drain();
        chk("clean_cnt", corr_count, 0);

        // data-bit error, parity-bit error, uncorrectable
        send(11'h53F, mk(7'h55, 1, 0, 4'd5), cyc);
        drain();
        chk("corr_cnt1", corr_count, 1);
        send(11'h52E, mk(7'h55, 1, 0, 4'd1), cyc);
        drain();
        chk("corr_cnt2", corr_count, 2);
        send(11'h5A7, mk(7'h55, 0, 1, 4'd12), cyc);
        drain();
        chk("uncorr_cnt1", uncorr_count, 1);
        chk("corr_cnt2b", corr_count, 2);

        // backpressure: 5 words, out_ready low for 4 cycles
        out_ready = 1'b0;
        exp_ir = 4'b0011; // bit k = expected in_ready in cycle k
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    logic [6:0] d;
                    int unsigned c2;
                    d = 7'(i * 23 + 9);
                    send(encode(d), mk(d, 0, 0, 4'd0), c2);
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, exp_ir[k]);
                    if (k >= 2) chk("bp_out_valid", out_valid, 1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // exhaustive: all data x {no error, each single bit}, full throughput
        sum = 0;
        for (int d = 0; d < 128; d++) begin
            for (int e = 0; e < 12; e++) begin
                logic [10:0] c;
                c = encode(7'(d));
                if (e > 0) c[e-1] = ~c[e-1];
                send(c, mk(7'(d), e != 0, 0, 4'(e)), cyc);
                sum += cyc;
            end
        end
        chk("throughput", sum, 128 * 12);
        drain();
        chk("sat_corr", corr_count, 3);
        chk("sat_uncorr_hold", uncorr_count, 1);

        // standalone clear
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        chk("clear_counts", {corr_count, uncorr_count}, 0);

        // five corrected words saturate a 2-bit counter at 3
        for (int i = 0; i < 5; i++) begin
            logic [10:0] c;
            c = encode(7'(i + 40));
            c[6] = ~c[6];
            send(c, mk(7'(i + 40), 1, 0, 4'd7), cyc);
        end
        drain();
        chk("sat5_corr", corr_count, 3);

        // clear coincident with a corrected output transfer
        send(11'h53F, mk(7'h55, 1, 0, 4'd5), cyc);
        @(posedge clk); #1;
        chk("coinc_valid", out_valid, 1);
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        chk("coinc_clear", corr_count, 0);
        drain();

        // asynchronous reset with words in flight
        send(11'h53F, mk(7'h55, 1, 0, 4'd5), cyc);
        send(11'h52E, mk(7'h55, 1, 0, 4'd1), cyc);
        drain();
        chk("pre_rst_corr", corr_count, 2);
        out_ready = 1'b0;
        send(encode(7'h12), mk(7'h12, 0, 0, 4'd0), cyc);
        send(encode(7'h34), mk(7'h34, 0, 0, 4'd0), cyc);
        chk("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_counts", {corr_count, uncorr_count}, 0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", out_valid, 0);
        send(11'h52F, mk(7'h55, 0, 0, 4'd0), cyc);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
